// File: rtl/bkram_pkg.sv
// Shared types for the backup-RAM SD sequencer.
// FSM state encoding and sector index width helper.
package bkram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK_HI,
    ACK_LO
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bkram_sd_ctrl_edge_det.sv
// Registered rise/fall pulse generator.
// Pulses appear one cycle after the input edge is sampled.
module edge_det (
  input  logic clk_sys,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      prev <= d;
      rise <= d & ~prev;
      fall <= ~d & prev;
    end
  end

endmodule

// File: rtl/bkram_sd_ctrl.sv
// Backup-RAM <-> SD sector sequencer.
// Load/save/auto-load/autosave with dirty tracking.
module bkram_sd_ctrl
  import bkram_pkg::*;
#(
  parameter int SECTORS = 64,
  parameter int LBA_W   = 32
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             downloading,
  input  logic             img_mounted,
  input  logic             img_readonly,
  input  logic             img_size_nz,
  input  logic             bk_load,
  input  logic             bk_save,
  input  logic             osd_status,
  input  logic             autosave_en,
  input  logic             nvram_we,
  input  logic             sd_ack,
  output logic [LBA_W-1:0] sd_lba,
  output logic             sd_rd,
  output logic             sd_wr,
  output logic             bk_ena,
  output logic             bk_loading,
  output logic             bk_busy,
  output logic             bk_dirty
);

  localparam int IW = idx_w(SECTORS);

  logic load_rq, save_rq, osd_rise;
  logic dl_rise, dl_end;
  logic ack_rise, ack_fall;
  logic load_fall, save_fall, osd_fall;
  logic unused_fall;

  assign unused_fall = &{1'b0, load_fall,
                         save_fall, osd_fall};

  edge_det u_load (
    .clk_sys (clk_sys),
    .reset   (reset),
    .d       (bk_load & bk_ena),
    .rise    (load_rq),
    .fall    (load_fall)
  );

  edge_det u_save (
    .clk_sys (clk_sys),
    .reset   (reset),
    .d       (bk_save & bk_ena),
    .rise    (save_rq),
    .fall    (save_fall)
  );

  edge_det u_osd (
    .clk_sys (clk_sys),
    .reset   (reset),
    .d       (osd_status),
    .rise    (osd_rise),
    .fall    (osd_fall)
  );

  edge_det u_dl (
    .clk_sys (clk_sys),
    .reset   (reset),
    .d       (downloading),
    .rise    (dl_rise),
    .fall    (dl_end)
  );

  edge_det u_ack (
    .clk_sys (clk_sys),
    .reset   (reset),
    .d       (sd_ack),
    .rise    (ack_rise),
    .fall    (ack_fall)
  );

  state_t           state, state_n;
  logic [LBA_W-1:0] lba_n;
  logic             rd_n, wr_n;
  logic             loading_n, busy_n;
  logic             dirty_n, ena_n;
  logic             auto_ld, auto_sv;
  logic             is_load, save_go, load_done;
  logic             last;

  assign auto_ld = dl_end & img_size_nz & bk_ena;
  assign auto_sv = osd_rise & autosave_en
                 & bk_dirty & bk_ena;
  assign last    = &sd_lba[IW-1:0];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      sd_lba     <= '0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      bk_loading <= 1'b0;
      bk_busy    <= 1'b0;
      bk_dirty   <= 1'b0;
      bk_ena     <= 1'b0;
    end else begin
      state      <= state_n;
      sd_lba     <= lba_n;
      sd_rd      <= rd_n;
      sd_wr      <= wr_n;
      bk_loading <= loading_n;
      bk_busy    <= busy_n;
      bk_dirty   <= dirty_n;
      bk_ena     <= ena_n;
    end
  end

  always_comb begin
    state_n   = state;
    lba_n     = sd_lba;
    rd_n      = sd_rd;
    wr_n      = sd_wr;
    loading_n = bk_loading;
    busy_n    = bk_busy;
    is_load   = 1'b0;
    save_go   = 1'b0;
    load_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_rq | save_rq |
            auto_ld | auto_sv) begin
          is_load   = load_rq
                    | (~save_rq & auto_ld);
          lba_n     = '0;
          loading_n = is_load;
          busy_n    = 1'b1;
          save_go   = ~is_load;
          state_n   = REQ;
        end
      end
      REQ: begin
        rd_n    = bk_loading;
        wr_n    = ~bk_loading;
        state_n = ACK_HI;
      end
      ACK_HI: begin
        if (ack_rise) begin
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          state_n = ACK_LO;
        end
      end
      ACK_LO: begin
        if (ack_fall) begin
          if (last) begin
            loading_n = 1'b0;
            busy_n    = 1'b0;
            load_done = bk_loading;
            state_n   = IDLE;
          end else begin
            lba_n   = sd_lba + LBA_W'(1);
            state_n = REQ;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A write landing on the save-start cycle must survive the clear.
  always_comb begin
    dirty_n = bk_dirty;
    if (nvram_we & ~bk_loading)
      dirty_n = 1'b1;
    else if (save_go | load_done)
      dirty_n = 1'b0;
  end

  always_comb begin
    ena_n = bk_ena;
    if (downloading & img_mounted
        & ~img_readonly)
      ena_n = 1'b1;
    else if (dl_rise)
      ena_n = 1'b0;
  end

endmodule

// File: tb/tb_bkram_sd_ctrl.sv
// Self-checking bench for bkram_sd_ctrl.
// Transaction-level model of the sector sequence and dirty flag.
module tb_bkram_sd_ctrl;

  localparam int SECTORS = 64;
  localparam int LBA_W   = 32;

  logic             clk_sys = 1'b0;
  logic             reset = 1'b1;
  logic             downloading = 1'b0;
  logic             img_mounted = 1'b0;
  logic             img_readonly = 1'b0;
  logic             img_size_nz = 1'b0;
  logic             bk_load = 1'b0;
  logic             bk_save = 1'b0;
  logic             osd_status = 1'b0;
  logic             autosave_en = 1'b0;
  logic             nvram_we = 1'b0;
  logic             sd_ack = 1'b0;
  logic [LBA_W-1:0] sd_lba;
  logic             sd_rd, sd_wr;
  logic             bk_ena, bk_loading;
  logic             bk_busy, bk_dirty;

  always #5 clk_sys = ~clk_sys;

  bkram_sd_ctrl #(
    .SECTORS (SECTORS),
    .LBA_W   (LBA_W)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .downloading  (downloading),
    .img_mounted  (img_mounted),
    .img_readonly (img_readonly),
    .img_size_nz  (img_size_nz),
    .bk_load      (bk_load),
    .bk_save      (bk_save),
    .osd_status   (osd_status),
    .autosave_en  (autosave_en),
    .nvram_we     (nvram_we),
    .sd_ack       (sd_ack),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .bk_ena       (bk_ena),
    .bk_loading   (bk_loading),
    .bk_busy      (bk_busy),
    .bk_dirty     (bk_dirty)
  );

  int   errors = 0;
  int   checks = 0;
  // 0: no transfer allowed, 1: load, 2: save
  int   exp_xfer = 0;
  int   req_cnt = 0;
  logic m_dirty = 1'b0;
  logic req_q = 1'b0;
  logic busy_q = 1'b0;
  logic cur_req;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_lba"}, sd_lba, 0);
    check({tag, "_rd"}, sd_rd, 0);
    check({tag, "_wr"}, sd_wr, 0);
    check({tag, "_ena"}, bk_ena, 0);
    check({tag, "_loading"}, bk_loading, 0);
    check({tag, "_busy"}, bk_busy, 0);
    check({tag, "_dirty"}, bk_dirty, 0);
  endtask

  task automatic expect_xfer(input int kind);
    exp_xfer = kind;
    req_cnt  = 0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!bk_busy && n < 20) begin
      tick();
      n++;
    end
    check("xfer_start", bk_busy, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (bk_busy && n < 3000) begin
      tick();
      n++;
    end
    check("xfer_done", bk_busy, 0);
    check("xfer_count", req_cnt, SECTORS);
    exp_xfer = 0;
  endtask

  task automatic pulse_we();
    nvram_we = 1'b1;
    tick();
    nvram_we = 1'b0;
  endtask

  task automatic mount(input logic ro);
    downloading = 1'b1;
    repeat (3) tick();
    img_readonly = ro;
    img_mounted  = 1'b1;
    tick();
    img_mounted = 1'b0;
    tick();
  endtask

  // hps_io stand-in: ack high 3 cycles, low 2, per request
  initial begin
    forever begin
      tick();
      if ((sd_rd | sd_wr) && !sd_ack) begin
        sd_ack = 1'b1;
        repeat (3) tick();
        sd_ack = 1'b0;
        repeat (2) tick();
      end
    end
  end

  always @(negedge clk_sys) begin
    if (reset) begin
      req_q  = 1'b0;
      busy_q = 1'b0;
    end else begin
      cur_req = sd_rd | sd_wr;
      if (exp_xfer == 0) begin
        check("idle_req", cur_req, 0);
      end else begin
        if (cur_req)
          check("rd_wr_excl", sd_rd & sd_wr, 0);
        if (bk_busy)
          check("loading_lvl", bk_loading,
                exp_xfer == 1);
        if (cur_req && !req_q) begin
          check("req_dir", sd_rd, exp_xfer == 1);
          check("req_lba", sd_lba, req_cnt);
          req_cnt++;
        end
        if (busy_q && !bk_busy) begin
          check("end_len", req_cnt, SECTORS);
          check("end_lba", sd_lba, SECTORS - 1);
          check("end_loading", bk_loading, 0);
        end
      end
      req_q  = cur_req;
      busy_q = bk_busy;
    end
  end

  initial begin
    int k;
    int n;
    repeat (3) tick();
    all_zero("reset");
    reset = 1'b0;
    tick();

    // auto-load after ROM download
    img_size_nz = 1'b1;
    mount(1'b0);
    check("ena_set", bk_ena, 1);
    expect_xfer(1);
    downloading = 1'b0;
    wait_start();
    check("load_flag", bk_loading, 1);
    repeat (20) tick();
    pulse_we();
    wait_done();
    m_dirty = 1'b0;
    check("load_dirty", bk_dirty, m_dirty);
    check("load_end_ena", bk_ena, 1);

    // manual saves with random write traffic
    for (int it = 0; it < 2; it++) begin
      k = $urandom_range(0, 3);
      if (it == 0) k = k + 1;
      for (int w = 0; w < k; w++) begin
        pulse_we();
        m_dirty = 1'b1;
        repeat ($urandom_range(0, 3)) tick();
      end
      check("pre_save_dirty", bk_dirty, m_dirty);
      expect_xfer(2);
      bk_save = 1'b1;
      tick();
      tick();
      bk_save = 1'b0;
      wait_start();
      m_dirty = 1'b0;
      check("save_clr", bk_dirty, m_dirty);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(10, 200)) tick();
        pulse_we();
        m_dirty = 1'b1;
      end
      wait_done();
      check("post_save_dirty", bk_dirty, m_dirty);
    end

    // load beats save; mid-transfer save is dropped
    expect_xfer(1);
    bk_load = 1'b1;
    bk_save = 1'b1;
    tick();
    tick();
    bk_load = 1'b0;
    bk_save = 1'b0;
    wait_start();
    n = 0;
    while (req_cnt < 10 && n < 500) begin
      tick();
      n++;
    end
    bk_save = 1'b1;
    tick();
    tick();
    bk_save = 1'b0;
    wait_done();
    m_dirty = 1'b0;
    check("both_dirty", bk_dirty, m_dirty);
    repeat (20) tick();
    check("no_queued", bk_busy, 0);

    // autosave on OSD open, only when dirty
    autosave_en = 1'b1;
    pulse_we();
    m_dirty = 1'b1;
    check("as_dirty", bk_dirty, m_dirty);
    expect_xfer(2);
    osd_status = 1'b1;
    tick();
    wait_start();
    osd_status = 1'b0;
    wait_done();
    m_dirty = 1'b0;
    check("as_clean", bk_dirty, m_dirty);
    repeat (3) tick();
    osd_status = 1'b1;
    repeat (30) tick();
    check("as_clean_osd", bk_busy, 0);
    osd_status = 1'b0;
    autosave_en = 1'b0;
    tick();

    // read-only image disables backup RAM
    mount(1'b1);
    check("ro_ena", bk_ena, 0);
    downloading = 1'b0;
    repeat (5) tick();
    bk_load = 1'b1;
    tick();
    tick();
    bk_load = 1'b0;
    bk_save = 1'b1;
    tick();
    tick();
    bk_save = 1'b0;
    repeat (40) tick();
    check("ro_busy", bk_busy, 0);
    check("ro_ena2", bk_ena, 0);
    img_readonly = 1'b0;

    // reset in the middle of sector 17
    img_size_nz = 1'b0;
    mount(1'b0);
    downloading = 1'b0;
    repeat (5) tick();
    check("rst_ena", bk_ena, 1);
    expect_xfer(2);
    bk_save = 1'b1;
    tick();
    tick();
    bk_save = 1'b0;
    wait_start();
    n = 0;
    while (!(sd_wr && sd_lba == 17) && n < 2000) begin
      tick();
      n++;
    end
    check("lba17", sd_lba, 17);
    check("lba17_req", req_cnt, 18);
    exp_xfer = 0;
    reset = 1'b1;
    tick();
    all_zero("midrst");
    reset = 1'b0;
    repeat (40) tick();
    check("post_rst_busy", bk_busy, 0);
    check("post_rst_lba", sd_lba, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/bkram_sd_ctrl.md
Name: bkram_sd_ctrl

Overview:
- Sequences backup-RAM (cartridge NVRAM) transfers between the 32 KB NVRAM dual-port buffer and the HPS SD block interface, one 512-byte sector per handshake.
- Sits between hps_io (sd_lba/sd_rd/sd_wr/sd_ack, img_* signals) and the top-level status/OSD bits.
- Handles manual load/save, auto-load after ROM download and dirty-tracked autosave when the OSD opens.
- Exports bk_loading, which the top level ORs into the system reset.

Parameters:
- SECTORS, 64, sectors per transfer (32 KB / 512 B); power of two, 2..64.
- LBA_W, 32, width of sd_lba.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high. Driven by the top-level RESET only, never by the system reset, which itself includes bk_loading.
- downloading  in  1  ioctl_download level.
- img_mounted  in  1  save image mount strobe from hps_io.
- img_readonly  in  1  mounted image is read-only.
- img_size_nz  in  1  mounted image size is non-zero.
- bk_load  in  1  OSD "Load Backup RAM" status level.
- bk_save  in  1  OSD "Save Backup RAM" status level.
- osd_status  in  1  OSD open level.
- autosave_en  in  1  enables autosave on OSD open.
- nvram_we  in  1  system-side NVRAM write strobe, used for dirty tracking.
- sd_ack  in  1  hps_io sector acknowledge.
- sd_lba  out  LBA_W  current sector.
- sd_rd  out  1  sector read request.
- sd_wr  out  1  sector write request.
- bk_ena  out  1  valid writable save image is mounted.
- bk_loading  out  1  load in progress.
- bk_busy  out  1  any transfer in progress.
- bk_dirty  out  1  NVRAM modified since the last load or save start.

Behaviour:
- Reset value of every output is 0. Reset mid-transfer returns the FSM to IDLE immediately; no further request is issued.
- bk_ena:
  - Cleared on the rising edge of downloading.
  - Set on any cycle with downloading & img_mounted & ~img_readonly.
  - Otherwise holds.
- Edge detectors, registered 1 cycle: load_rq = rise(bk_load & bk_ena); save_rq = rise(bk_save & bk_ena); dl_end = fall(downloading); osd_rise = rise(osd_status).
- FSM states: IDLE, REQ, ACK_HI, ACK_LO.
- IDLE, start priority is load_rq > save_rq > auto-load > autosave:
  - auto-load = dl_end & img_size_nz & bk_ena.
  - autosave = osd_rise & autosave_en & bk_dirty & bk_ena.
  - On a start: sd_lba <= 0; bk_loading <= is_load; bk_busy <= 1; go to REQ.
  - A save start clears bk_dirty.
  - Start conditions arriving while busy are dropped, not queued.
- REQ: assert sd_rd = bk_loading or sd_wr = ~bk_loading, on the cycle after entry. Go to ACK_HI.
- ACK_HI: wait for a sd_ack rising edge, then drop sd_rd and sd_wr on the next cycle and go to ACK_LO.
- ACK_LO: wait for a sd_ack falling edge.
  - If sd_lba[log2(SECTORS)-1:0] is all ones: bk_loading <= 0, bk_busy <= 0, go to IDLE.
  - Otherwise: sd_lba <= sd_lba + 1 and return to REQ.
  - The full transfer is exactly SECTORS request/ack pairs, LBA 0..SECTORS-1; sd_lba never wraps.
- Exactly one of sd_rd/sd_wr is high while requesting; never both.
- bk_dirty:
  - Set on nvram_we while not bk_loading.
  - Cleared on save start and on load completion.
  - nvram_we during a save re-sets it.
  - nvram_we coinciding with the save-start clear leaves it set.
- sd_ack asserted while in IDLE is ignored.
- No timeout: hps_io guarantees the ack.

Decomposition:
- Package bkram_pkg: FSM state enum (IDLE, REQ, ACK_HI, ACK_LO); the SECTORS-derived index width function.
- One sub-module, edge_det (rise/fall pulse generator), instantiated per input edge.
- The FSM and dirty logic stay in bkram_sd_ctrl.

Test Plan:
- Save: bk_ena=1, pulse bk_save; bench acks each request (ack high 3 cycles, low 2) -> 64 sd_wr pulses, sd_lba 0..63, bk_busy falls after the 64th ack fall, sd_lba=63, bk_dirty=0.
- Auto-load: downloading 1->0 with img_mounted seen during download, img_readonly=0, img_size_nz=1 -> 64 sd_rd requests, bk_loading high throughout, 0 afterwards.
- Read-only image: img_readonly=1 during download, then pulse bk_load and bk_save -> bk_ena=0, no sd_rd/sd_wr ever asserted.
- Simultaneous bk_load and bk_save rise -> load chosen (sd_rd=1, sd_wr=0). A bk_save rise mid-transfer is ignored; the total stays 64 requests.
- Autosave: autosave_en=1, single nvram_we, then osd_status rise -> save sequence starts. A second osd_rise with no further writes -> no transfer.
- Reset asserted at sd_lba=17 in ACK_HI -> next cycle all outputs 0 including bk_ena. A later sd_ack is ignored and no request is issued.
